// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write path.
package regfile_pkg;
    localparam int REGFILE_N_REG = 32;
    localparam int REGFILE_WIDTH = 32;
    localparam int REGFILE_AW    = (REGFILE_N_REG > 1) ? $clog2(REGFILE_N_REG) : 1;
    localparam int STALL_CNT_W   = 16;

    typedef logic [REGFILE_AW-1:0] regfile_addr_t;
endpackage

// File: rtl/regfile_wr_arb_rr_arbiter.sv
// Round-robin arbiter: scans from rr_ptr, grants the first requester, and
// moves the pointer just past the winner when advance is set.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic          found;
    int            j;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        gnt     = '0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(rr_ptr_q) + k) % N;
            if (!found && req[j]) begin
                found   = 1'b1;
                gnt_idx = PW'(j);
            end
        end
        // No handshake may be offered while reset is held.
        if (found && !rst) gnt[gnt_idx] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance && (|gnt))
            rr_ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/regfile_wr_arb.sv
// Register-file write arbiter: round-robin over N_REQ producers into one
// registered write port. Optional REGFILE_WR_ARB_STATS_EN adds stall counters.
import regfile_pkg::*;

module regfile_wr_arb #(
    parameter int WIDTH = REGFILE_WIDTH,
    parameter int N_REG = REGFILE_N_REG,
    parameter int N_REQ = 4,
    parameter int AW    = (N_REG > 1) ? $clog2(N_REG) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0][AW-1:0]      req_addr,
    input  logic [N_REQ-1:0][WIDTH-1:0]   req_data,
    output logic                          wen,
    output logic [AW-1:0]                 waddr,
    output logic [WIDTH-1:0]              wdata,
`ifdef REGFILE_WR_ARB_STATS_EN
    output logic [N_REQ-1:0][STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic                          err_oob
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0] gnt;
    logic [PW-1:0]    gnt_idx;
    logic             any_gnt, oob;
    logic [AW-1:0]    sel_addr;
    logic             wen_q, wen_d, err_oob_q, err_oob_d;
    logic [AW-1:0]    waddr_q, waddr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    rr_arbiter #(.N(N_REQ), .PW(PW)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (1'b1),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;

    always_comb begin
        any_gnt  = |gnt;
        sel_addr = req_addr[gnt_idx];
        oob      = 32'(sel_addr) >= 32'(N_REG);
        // Out-of-range requests are consumed but never reach the write port.
        wen_d     = any_gnt && !oob;
        err_oob_d = any_gnt && oob;
        waddr_d   = wen_d ? sel_addr : waddr_q;
        wdata_d   = wen_d ? req_data[gnt_idx] : wdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q     <= 1'b0;
            err_oob_q <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            wen_q     <= wen_d;
            err_oob_q <= err_oob_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign wen     = wen_q;
    assign err_oob = err_oob_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;

`ifdef REGFILE_WR_ARB_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_stall
        logic [STALL_CNT_W-1:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (req_valid[i] && !req_ready[i] && (cnt_q != {STALL_CNT_W{1'b1}}))
                cnt_d = cnt_q + 1'b1;
        end
        always_ff @(posedge clk) begin
            if (rst) cnt_q <= '0;
            else     cnt_q <= cnt_d;
        end
        assign stall_cnt[i] = cnt_q;
    end
`endif
endmodule

// File: doc/regfile_wr_arb.md
# regfile_wr_arb

Write-side front end for the register file: collects write requests from `N_REQ` independent producers (execution units, load return, CSR path) over valid/ready handshakes, and arbitrates round-robin. It drives the register file's single write port (`waddr`/`wen`/`wdata`) from a registered output stage. It sits directly upstream of the register file. It guarantees at most one write per cycle, fair service, and a clean drop of out-of-range addresses.

## Interface
- `WIDTH`, 32, data width of each register; must match the register file.
- `N_REG`, 32, number of registers; `AW = $clog2(N_REG)` (min 1).
- `N_REQ`, 4, number of requesting producers, ≥1.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  [N_REQ]  producer i has a write pending.
- `req_ready`  out  [N_REQ]  producer i granted this cycle (one-hot or zero).
- `req_addr`  in  [N_REQ][AW]  target register index.
- `req_data`  in  [N_REQ][WIDTH]  write data.
- `wen`  out  1  register file write enable (registered).
- `waddr`  out  [AW]  register file write address (registered).
- `wdata`  out  [WIDTH]  register file write data (registered).
- `err_oob`  out  1  one-cycle pulse: accepted request had `req_addr >= N_REG`.
- `stall_cnt`  out  [N_REQ][16]  per-producer stall counters (only with `REGFILE_WR_ARB_STATS_EN`).

## Operation
- Handshake: transfer on `req_valid[i] && req_ready[i]`. A producer holds valid, addr and data stable until it is accepted. `req_ready` is combinational from `req_valid` and the pointer. There is no combinational path from `req_addr`/`req_data` to `req_ready`.
- Arbitration: `rr_ptr` (`$clog2(N_REQ)` bits, reset 0). The grant is the first i with `req_valid[i]`, scanning `rr_ptr, rr_ptr+1, …` modulo `N_REQ`.
- Exactly one grant when any valid is asserted, none otherwise.
- On a grant to index g, `rr_ptr <= (g == N_REQ-1) ? 0 : g+1`. With no grant the pointer holds.
- Output stage:
  - On a grant with in-range address: `wen <= 1`, `waddr <= req_addr[g]`, `wdata <= req_data[g]`, `err_oob <= 0`.
  - On a grant with `req_addr[g] >= N_REG`: the request is consumed, `wen <= 0`, `err_oob <= 1`; `waddr`/`wdata` hold.
  - With no grant: `wen <= 0`, `err_oob <= 0`; `waddr`/`wdata` hold their last value.
- The register file always accepts, so there is no backpressure into this block. Every cycle can grant.
- `N_REQ = 1`: the pointer is constant 0, and `req_ready[0] = req_valid[0]` outside reset.
- Reset values: `wen=0`, `waddr=0`, `wdata=0`, `err_oob=0`, `rr_ptr=0`, `stall_cnt=0`.
- While `rst` is high, `req_ready` is all zero.
- Reset asserted mid-stream: a grant in the reset cycle is not issued. The output register takes reset values on the next edge, so a pending write in flight is lost and the producer still sees no handshake.

## Timing
- Request accepted in cycle n → `wen`/`waddr`/`wdata` valid in cycle n+1. The register file updates at the end of n+1, so it is readable in n+2.
- Throughput is one write per cycle. A continuously-valid producer among k valid producers is served every k cycles; worst-case wait is `N_REQ-1` cycles.
- Two producers writing the same address in consecutive grants are written in grant order. The later grant wins.

## Configuration
- `REGFILE_WR_ARB_STATS_EN` defined:
  - `stall_cnt[i]` increments each cycle with `req_valid[i] && !req_ready[i]` and `!rst`.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined: `stall_cnt` port and counters are absent. All other behaviour is identical.

## Structure
- `regfile_pkg` holds `regfile_addr_t` (AW-wide, from package constant `REGFILE_N_REG`), `REGFILE_WIDTH`, and `STALL_CNT_W = 16`.
- Sub-module `rr_arbiter` (params `N`). Inputs are `clk`, `rst`, `req[N]` and `advance`; outputs are one-hot `gnt[N]` and binary `gnt_idx`. It owns `rr_ptr` and its wrap.
- The top level instantiates it and adds the output register, the OOB check and the stats counters.

## Test plan
- Reset, then single producer 0 with addr 5, data 0xDEADBEEF for one cycle → `req_ready[0]=1` that cycle; next cycle `wen=1`, `waddr=5`, `wdata=0xDEADBEEF`; the cycle after, `wen=0`.
- All 4 producers valid continuously for 8 cycles from reset → grants in order 0,1,2,3,0,1,2,3 and `wen=1` on every cycle from cycle 1 on.
- Producers 1 and 3 valid with `rr_ptr=2` → grant 3, then 1, then 3. This checks the wrap from index 3 to 0 skipping idle entries.
- `N_REG=24`, producer 2 requests addr 30 → `req_ready[2]=1`; next cycle `err_oob=1`, `wen=0`, `waddr`/`wdata` unchanged.
- Assert `rst` in the cycle after a grant to producer 1 → `wen=0` after reset, `rr_ptr=0`, no `req_ready` during reset; producer 1, still valid, is regranted first after release.
- With `REGFILE_WR_ARB_STATS_EN`: producers 0–3 all valid for 12 cycles → each `stall_cnt` = 9. Forcing a counter to 0xFFFE and stalling 3 more cycles → it holds at 0xFFFF.
